// File: rtl/stump_control.sv
// Stump multi-cycle control unit: fetch/execute/memory sequencer, instruction
// decode, condition-code register and Bcc evaluation.
module stump_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [3:0]  flags_in,
    output logic [1:0]  state,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic        addr_load,
    output logic        addr_sel,
    output logic [2:0]  alu_func,
    output logic        alu_c_in,
    output logic        imm_sel,
    output logic        imm8,
    output logic [1:0]  shift_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [2:0]  reg_dest,
    output logic [2:0]  reg_srcA,
    output logic [2:0]  reg_srcB,
    output logic [3:0]  cc_out,
    output logic        branch_taken
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXECUTE = 2'b01,
        S_MEMORY  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    state_t      state_q, state_d;
    logic [3:0]  cc_q, cc_d;

    logic [2:0]  op;
    logic        imm_type;
    logic        s_bit;
    logic [2:0]  dest;
    logic [1:0]  shift;
    logic [3:0]  cond;
    logic        write_req;

    assign op       = ir[15:13];
    assign imm_type = ir[12];
    assign s_bit    = ir[11];
    assign dest     = ir[10:8];
    assign shift    = ir[4:3];
    assign cond     = ir[11:8];

    // Condition table over stored flags {N,Z,V,C}.
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] cc);
        logic n, z, v, cy;
        n  = cc[3];
        z  = cc[2];
        v  = cc[1];
        cy = cc[0];
        case (c)
            4'h0: cond_true = 1'b1;
            4'h1: cond_true = 1'b0;
            4'h2: cond_true = cy & ~z;
            4'h3: cond_true = ~cy | z;
            4'h4: cond_true = ~cy;
            4'h5: cond_true = cy;
            4'h6: cond_true = ~z;
            4'h7: cond_true = z;
            4'h8: cond_true = ~v;
            4'h9: cond_true = v;
            4'hA: cond_true = ~n;
            4'hB: cond_true = n;
            4'hC: cond_true = n ~^ v;
            4'hD: cond_true = n ^ v;
            4'hE: cond_true = ~z & (n ~^ v);
            default: cond_true = z | (n ^ v);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cc_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        cc_d         = cc_q;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        mem_ren      = 1'b0;
        mem_wen      = 1'b0;
        addr_load    = 1'b0;
        addr_sel     = 1'b0;
        alu_func     = 3'b000;
        alu_c_in     = 1'b0;
        imm_sel      = 1'b0;
        imm8         = 1'b0;
        shift_op     = 2'b00;
        write_req    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dest     = dest;
        reg_srcA     = ir[7:5];
        reg_srcB     = ir[2:0];
        branch_taken = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_ren = 1'b1;
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                if (op == OP_LDST) begin
                    imm_sel   = imm_type;
                    shift_op  = imm_type ? 2'b00 : shift;
                    addr_load = 1'b1;
                    state_d   = S_MEMORY;
                end else if (op == OP_BCC) begin
                    reg_srcA     = 3'd7;
                    reg_dest     = 3'd7;
                    imm_sel      = 1'b1;
                    imm8         = 1'b1;
                    branch_taken = cond_true(cond, cc_q);
                    write_req    = branch_taken;
                end else begin
                    alu_func  = op;
                    imm_sel   = imm_type;
                    shift_op  = imm_type ? 2'b00 : shift;
                    write_req = 1'b1;
                    // Carry-in comes from flags stored before this EXECUTE.
                    alu_c_in  = ((op == OP_ADC) || (op == OP_SBC)) ? cc_q[0] : 1'b0;
                    if (s_bit) begin
                        cc_d = flags_in;
                    end
                end
            end
            S_MEMORY: begin
                addr_sel = 1'b1;
                if (s_bit) begin
                    mem_wen  = 1'b1;
                    reg_srcA = dest;
                end else begin
                    mem_ren    = 1'b1;
                    write_req  = 1'b1;
                    mem_to_reg = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // R0 is hardwired zero, so writes to it are dropped.
        reg_write = write_req && (reg_dest != 3'd0);

        if (rst) begin
            ir_load   = 1'b0;
            pc_inc    = 1'b0;
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            addr_load = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign state  = state_q;
    assign cc_out = cc_q;

endmodule
